icache_refill_axi: RTL
======================

Name: icache_refill_axi

Overview:
- Downstream neighbour of the instruction cache: consumes the cache's line-refill request (rd_req/rd_addr/rd_rdy) and returns a full 128-bit line (ret_valid/ret_data).
- Converts each refill into one AXI4 INCR read burst of WORDS_PER_LINE beats, assembles the beats and presents the line to the cache.
- Sits between the ICache and the core's AXI crossbar/arbiter.

Parameters:
- AXI_ID, 4'h0, ARID driven on every burst.
- WORDS_PER_LINE, 4, 32-bit words per cache line; the line is WORDS_PER_LINE*32 bits.
- OFFSET_W, 4, byte-offset bits cleared when aligning rd_addr (log2 of line bytes).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- rd_req  in  1  cache requests a line refill
- rd_addr  in  32  physical address of the line
- rd_rdy  out  1  request accepted when rd_req&&rd_rdy
- ret_valid  out  1  one-cycle pulse, ret_data holds the full line
- ret_data  out  128  assembled line, word i at bits [32i+31:32i]
- arid  out  4  read ID = AXI_ID
- araddr  out  32  line-aligned address
- arlen  out  8  WORDS_PER_LINE-1
- arsize  out  3  3'b010 (4 bytes)
- arburst  out  2  2'b01 (INCR)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  read data ID (not checked)
- rdata  in  32  read beat
- rresp  in  2  beat response
- rlast  in  1  last beat
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Reset: state IDLE, rd_rdy=1, ret_valid=0, ret_data=0, arvalid=0, rready=0, araddr=0, beat counter=0. Reset is asynchronous, including mid-burst. The AXI side is reset globally, so abandoning a burst on reset is legal.
- FSM states are IDLE, AR, R, RET.
- IDLE: rd_rdy=1 (combinational, state==IDLE only). On rd_req: latch {rd_addr[31:OFFSET_W], 0}, clear beat counter, go to AR.
- AR: arvalid=1 with araddr, arlen, arsize and arburst held stable. On arready: go to R. AR is never dropped before the handshake.
- R: rready=1. On each rvalid, write rdata into word slot [beat counter], then counter+1.
  - Leave to RET on the beat with rlast=1 or counter==WORDS_PER_LINE-1, whichever comes first.
  - Beats arriving after that are not accepted (rready=0 outside R).
- RET: ret_valid=1 for exactly one cycle, then IDLE. ret_data stays stable from RET until the next accept.
- Latency with zero-wait slave: accept at cycle 0, AR at 1, beats at 2..5, ret_valid at 6. Minimum request-to-ret_valid is WORDS_PER_LINE+2 cycles.
- rd_rdy=0 in AR/R/RET; rd_req there is ignored and not queued. The cache keeps rd_req high in MISS, so it retries.
- A back-to-back request is accepted in the IDLE cycle following RET, never in RET itself.
- The counter is log2(WORDS_PER_LINE) bits and never wraps inside a burst.
- rid and rresp are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: ICACHE_REFILL_ERR_CHECK_EN.
- With it: adds output err (1 bit, reset 0, sticky until reset). err sets on any accepted beat with rresp!=2'b00, or when rlast disagrees with counter==WORDS_PER_LINE-1. The line is still returned normally.
- Without it: port err is absent; rresp and rlast mismatches are ignored (early rlast still terminates the burst).

Decomposition:
- Shared package cache_axi_pkg holds:
  - refill state enum;
  - constants AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, AXI_RESP_OKAY=2'b00;
  - LINE_W = WORDS_PER_LINE*32.
- One sub-module is natural: icache_line_buf (beat write-by-index register file with clear, producing ret_data). Everything else stays in the top.

Test Plan:
- Zero-wait refill: rd_req, rd_addr=32'h1FC0_0124; slave arready=1, beats 11111111,22222222,33333333,44444444 -> araddr=32'h1FC0_0120, arlen=3, arsize=2, arburst=1; ret_valid pulses once at cycle 6; ret_data=128'h44444444_33333333_22222222_11111111.
- Backpressure: arready low for 3 cycles, rvalid gaps between beats -> araddr/arvalid stable while waiting; beats land in the correct slots; still exactly one ret_valid pulse.
- Request while busy: rd_req held high through the burst -> rd_rdy=0 until the IDLE cycle after RET; a second burst is issued only then.
- Reset mid-burst: resetn low after beat 2 -> all outputs return to reset values immediately; a later request completes cleanly with no stale words.
- Early rlast on beat 3 (with ICACHE_REFILL_ERR_CHECK_EN) -> ret_valid follows, word 3 keeps its cleared value, err=1 and stays 1.
- rresp=2'b10 on beat 1 with the feature on -> err=1, line still returned; the same stimulus without the macro gives no err port and a normal return.

Source files
------------

// File: rtl/cache_axi_pkg.sv
// Shared types and constants for the instruction-cache line refill path.
package cache_axi_pkg;

    // Refill sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RET  = 2'd3
    } refill_state_e;

    // AXI encodings used by the refill master
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Default line geometry: 32-bit words per line and the resulting line width
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned LINE_W     = LINE_WORDS * 32;

    // Width of a word index; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Line assembly buffer: one 32-bit register per word, written by beat index,
// cleared in one cycle when a new refill is accepted.
module icache_line_buf #(
    parameter int unsigned WORDS = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [31:0]           wdata_i,
    output logic [WORDS*32-1:0]   line_o
);

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            logic [31:0] word_q;

            // Clear takes priority so a fresh refill never shows words of the previous line
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    word_q <= '0;
                end else if (clr_i) begin
                    word_q <= '0;
                end else if (we_i && (idx_i == IDX_W'(gi))) begin
                    word_q <= wdata_i;
                end
            end

            assign line_o[gi*32 +: 32] = word_q;
        end
    endgenerate

endmodule

// File: rtl/icache_refill_axi.sv
// ICache line refill to AXI4 read bridge: turns one refill request into one
// INCR burst, collects the beats into a line and pulses ret_valid once.
// Optional sticky protocol-error flag: define ICACHE_REFILL_ERR_CHECK_EN.
module icache_refill_axi
    import cache_axi_pkg::*;
#(
    parameter logic [3:0]  AXI_ID         = 4'h0,
    parameter int unsigned WORDS_PER_LINE = LINE_WORDS,
    parameter int unsigned OFFSET_W       = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rd_req,
    input  logic [31:0]                   rd_addr,
    output logic                          rd_rdy,
    output logic                          ret_valid,
    output logic [WORDS_PER_LINE*32-1:0]  ret_data,
`ifdef ICACHE_REFILL_ERR_CHECK_EN
    output logic                          err,
`endif
    output logic [3:0]                    arid,
    output logic [31:0]                   araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [3:0]                    rid,
    input  logic [31:0]                   rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready
);

    localparam int unsigned      CNT_W    = cnt_width(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_LINE - 1);

    refill_state_e    state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic beat;
    logic last_beat;

    assign accept    = (state_q == ST_IDLE) && rd_req;
    assign beat      = (state_q == ST_R) && rvalid;
    // Whichever comes first ends the burst: slave's rlast or our own word count
    assign last_beat = beat && (rlast || (cnt_q == LAST_IDX));

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (rd_req)    state_d = ST_AR;
            ST_AR:   if (arready)   state_d = ST_R;
            ST_R:    if (last_beat) state_d = ST_RET;
            ST_RET:                 state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded purely from state
    always_comb begin
        rd_rdy    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        ret_valid = 1'b0;
        case (state_q)
            ST_IDLE: rd_rdy    = 1'b1;
            ST_AR:   arvalid   = 1'b1;
            ST_R:    rready    = 1'b1;
            ST_RET:  ret_valid = 1'b1;
            default: ;
        endcase
    end

    // Address latch and beat counter; counter holds on the final beat so it never wraps
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (accept) begin
            addr_d = {rd_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
            cnt_d  = '0;
        end else if (beat && !last_beat) begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    icache_line_buf #(
        .WORDS (WORDS_PER_LINE),
        .IDX_W (CNT_W)
    ) u_line_buf (
        .clk     (clk),
        .resetn  (resetn),
        .clr_i   (accept),
        .we_i    (beat),
        .idx_i   (cnt_q),
        .wdata_i (rdata),
        .line_o  (ret_data)
    );

    // AR channel fields are constant or come from the latched address, so they stay stable while waiting
    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'(WORDS_PER_LINE - 1);
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;

    logic unused_ok;

`ifdef ICACHE_REFILL_ERR_CHECK_EN
    logic err_q, err_d;

    // Sticky error: bad response or rlast not matching the expected final word
    always_comb begin
        err_d = err_q;
        if (beat && ((rresp != AXI_RESP_OKAY) || (rlast != (cnt_q == LAST_IDX)))) begin
            err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err       = err_q;
    assign unused_ok = ^{rid, rd_addr[OFFSET_W-1:0]};
`else
    assign unused_ok = ^{rid, rresp, rd_addr[OFFSET_W-1:0]};
`endif

endmodule
